// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of an in-order pipeline. Holds one instruction coming from EX,
// waits for the data SRAM response owed by loads/stores, extracts and extends
// load data, and hands the finished instruction to WB. A flushed instruction
// that still has an SRAM response in flight leaves a "discard" credit behind
// so the stale response is dropped when it eventually arrives.
//
// Handshake: a transfer across a stage boundary happens on a rising clk edge
// when the producer's valid and the consumer's allowin are both high in that
// cycle. valid never depends on the consumer's allowin; allowin may depend on
// downstream allowin. flush blocks both the incoming and outgoing transfer.
//
// Ports
//   clk, resetn           clock (rising edge), asynchronous active-low reset
//   es2ms_valid / ms_allowin      EX -> MEM handshake
//   ms2ws_valid / ws_allowin      MEM -> WB handshake
//   es_pc, es_alu_result, es_mem_req, es_res_from_mem, es_ld_op,
//   es_res_from_mul, es_mul_result, es_gr_we, es_dest
//                         instruction fields from EX, latched on entry
//   data_sram_data_ok, data_sram_rdata   SRAM response (one-cycle pulse)
//   flush                 cancel the instruction held in MEM
//   ms_pc, ms_gr_we, ms_dest, ms_final_result   instruction to WB/forwarding
//   ms_fwd_ready          ms_final_result is usable for forwarding this cycle
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int PC_W   = 32,
    parameter int DEST_W = 5,
    parameter int DISC_W = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es2ms_valid,
    output logic              ms_allowin,
    output logic              ms2ws_valid,
    input  logic              ws_allowin,
    input  logic [PC_W-1:0]   es_pc,
    input  logic [31:0]       es_alu_result,
    input  logic              es_mem_req,
    input  logic              es_res_from_mem,
    input  logic [2:0]        es_ld_op,
    input  logic              es_res_from_mul,
    input  logic [31:0]       es_mul_result,
    input  logic              es_gr_we,
    input  logic [DEST_W-1:0] es_dest,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    input  logic              flush,
    output logic [PC_W-1:0]   ms_pc,
    output logic              ms_gr_we,
    output logic [DEST_W-1:0] ms_dest,
    output logic [31:0]       ms_final_result,
    output logic              ms_fwd_ready
);

    // Registered instruction fields
    logic              r_ms_valid;
    logic [PC_W-1:0]   r_pc;
    logic [31:0]       r_alu_result;
    logic              r_mem_req;
    logic              r_res_from_mem;
    logic [2:0]        r_ld_op;
    logic              r_res_from_mul;
    logic [31:0]       r_mul_result;
    logic              r_gr_we;
    logic [DEST_W-1:0] r_dest;

    // Response tracking
    logic              r_resp_got;
    logic [31:0]       r_resp_buf;
    logic [DISC_W-1:0] r_disc_cnt;

    logic              w_disc_zero;
    logic              w_pending;
    logic              w_resp_take;
    logic              w_stale;
    logic              w_disc_inc;
    logic              w_ready_go;
    logic              w_latch;
    logic [31:0]       w_resp_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_val;

    assign w_disc_zero = (r_disc_cnt == '0);
    // The held instruction still owes an SRAM response.
    assign w_pending   = r_ms_valid & r_mem_req & ~r_resp_got;
    // While discard credits remain, every data_ok belongs to a flushed
    // instruction, so only a zero counter lets a response through.
    assign w_resp_take = data_sram_data_ok & w_disc_zero & w_pending;
    assign w_stale     = data_sram_data_ok & ~w_disc_zero;
    // A flush coincident with data_ok consumes that response, so no credit.
    assign w_disc_inc  = flush & w_pending & ~data_sram_data_ok
                         & (r_disc_cnt != {DISC_W{1'b1}});

    assign w_ready_go  = ~r_mem_req | r_resp_got | (data_sram_data_ok & w_disc_zero);
    assign ms_allowin  = ~r_ms_valid | (w_ready_go & ws_allowin);
    assign ms2ws_valid = r_ms_valid & w_ready_go & ~flush;
    assign w_latch     = es2ms_valid & ms_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid <= 1'b0;
        end else if (flush) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es2ms_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc           <= '0;
            r_alu_result   <= '0;
            r_mem_req      <= 1'b0;
            r_res_from_mem <= 1'b0;
            r_ld_op        <= '0;
            r_res_from_mul <= 1'b0;
            r_mul_result   <= '0;
            r_gr_we        <= 1'b0;
            r_dest         <= '0;
        end else if (w_latch) begin
            r_pc           <= es_pc;
            r_alu_result   <= es_alu_result;
            r_mem_req      <= es_mem_req;
            r_res_from_mem <= es_res_from_mem;
            r_ld_op        <= es_ld_op;
            r_res_from_mul <= es_res_from_mul;
            r_mul_result   <= es_mul_result;
            r_gr_we        <= es_gr_we;
            r_dest         <= es_dest;
        end
    end

    // The buffer keeps the response while WB stalls; a new instruction
    // entering always starts with no response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp_got <= 1'b0;
            r_resp_buf <= '0;
        end else if (w_latch) begin
            r_resp_got <= 1'b0;
        end else if (w_resp_take && !flush) begin
            r_resp_got <= 1'b1;
            r_resp_buf <= data_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_disc_cnt <= '0;
        end else if (w_stale) begin
            r_disc_cnt <= r_disc_cnt - 1'b1;
        end else if (w_disc_inc) begin
            r_disc_cnt <= r_disc_cnt + 1'b1;
        end
    end

    // Arrival cycle forwards the SRAM bus directly; afterwards the buffer.
    assign w_resp_word = r_resp_got ? r_resp_buf : data_sram_rdata;

    always_comb begin
        w_byte     = 8'h00;
        w_half     = 16'h0000;
        w_load_val = w_resp_word;
        case (r_alu_result[1:0])
            2'd0:    w_byte = w_resp_word[7:0];
            2'd1:    w_byte = w_resp_word[15:8];
            2'd2:    w_byte = w_resp_word[23:16];
            default: w_byte = w_resp_word[31:24];
        endcase
        // Misaligned halfword offsets only look at address bit 1.
        w_half = r_alu_result[1] ? w_resp_word[31:16] : w_resp_word[15:0];
        case (r_ld_op)
            3'd1:    w_load_val = {{24{w_byte[7]}}, w_byte};
            3'd2:    w_load_val = {{16{w_half[15]}}, w_half};
            3'd3:    w_load_val = {24'h000000, w_byte};
            3'd4:    w_load_val = {16'h0000, w_half};
            default: w_load_val = w_resp_word;
        endcase
    end

    assign ms_final_result = r_res_from_mem ? w_load_val :
                             r_res_from_mul ? r_mul_result : r_alu_result;
    assign ms_fwd_ready    = r_ms_valid & (~r_res_from_mem | w_ready_go);
    assign ms_pc           = r_pc;
    assign ms_gr_we        = r_ms_valid & r_gr_we;
    assign ms_dest         = r_dest;

    // A response with no owner and no discard credit means the SRAM and the
    // pipeline disagree about outstanding requests.
    a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (!resetn)
        !(data_sram_data_ok && w_disc_zero && !w_pending));

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameters: PC_W, default 32, PC width; DEST_W, default 5, register-index width; DISC_W, default 2, width of the discard counter for stale responses.
REQ-002 SHALL have ports (name direction width meaning), with clk and resetn first:
- clk  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- es2ms_valid  in  1  EX stage holds a valid instruction
- ms_allowin  out  1  MEM stage accepts an instruction this cycle
- ms2ws_valid  out  1  MEM stage presents a finished instruction
- ws_allowin  in  1  WB stage accepts an instruction
- es_pc  in  PC_W  instruction PC
- es_alu_result  in  32  ALU result, or load/store address
- es_mem_req  in  1  instruction issued an SRAM request in EX, so one data_ok is owed
- es_res_from_mem  in  1  instruction is a load
- es_ld_op  in  3  load type: 0=LW, 1=LB, 2=LH, 3=LBU, 4=LHU, others=LW
- es_res_from_mul  in  1  result comes from the multiplier
- es_mul_result  in  32  multiplier result, valid in the EX cycle
- es_gr_we  in  1  register write enable
- es_dest  in  DEST_W  destination register
- data_sram_data_ok  in  1  one-cycle pulse: SRAM response present
- data_sram_rdata  in  32  response data, valid with data_ok
- flush  in  1  cancel the instruction held in MEM
- ms_pc  out  PC_W  registered PC
- ms_gr_we  out  1  ms_valid & registered gr_we
- ms_dest  out  DEST_W  registered dest
- ms_final_result  out  32  result to WB and to forwarding
- ms_fwd_ready  out  1  ms_final_result is usable for forwarding this cycle

Function
REQ-003 SHALL compute ms_ready_go = ~mem_req_r | resp_got | (data_ok & disc_cnt==0).
REQ-004 SHALL drive ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin), and ms2ws_valid = ms_valid & ms_ready_go & ~flush.
REQ-005 SHALL, when ms_allowin is high, load ms_valid with es2ms_valid & ~flush; when es2ms_valid & ms_allowin, SHALL latch every es_* field in that same edge, with es_mul_result registered and not passed through.
REQ-006 SHALL treat a data_ok arriving while disc_cnt==0 and ms_valid & mem_req_r & ~resp_got as the current instruction's response: rdata captured into resp_buf, resp_got set.
REQ-007 SHALL clear resp_got whenever a new instruction is latched; resp_got and resp_buf SHALL hold while WB stalls, so data is never lost under backpressure.
REQ-008 SHALL forward rdata combinationally in the arrival cycle and the resp_buf value thereafter.
REQ-009 SHALL extract the load value from the response word using byte offset a = addr_r[1:0]:
- LB/LBU select byte a; LH/LHU select half a[1].
- Signed types (LB, LH) sign-extend to 32 bits; unsigned types (LBU, LHU) zero-extend.
- Misaligned halfword offsets use a[1] only.
REQ-010 SHALL select ms_final_result in this priority: res_from_mem → extended load value; res_from_mul → registered mul result; else registered alu_result.
REQ-011 SHALL drive ms_fwd_ready = ms_valid & (~res_from_mem_r | ms_ready_go).
REQ-012 SHALL handle flush while ms_valid as follows:
- ms_valid clears at the next edge.
- If mem_req_r & ~resp_got and no data_ok in that same cycle, disc_cnt increments (saturating at 2^DISC_W-1).
- Flush coincident with data_ok drops that response and leaves disc_cnt unchanged.
REQ-013 SHALL, on each data_ok while disc_cnt>0, decrement disc_cnt and discard the data, with no effect on resp_got and no effect on ms_ready_go.
REQ-014 SHALL treat flush with ms_valid=0 as a no-op, except that it blocks a simultaneous es2ms_valid from entering.
REQ-015 SHALL give a non-memory instruction (es_mem_req=0) a MEM latency of one cycle; a memory instruction SHALL leave in the cycle its data_ok arrives, at the earliest.
REQ-016 SHALL ignore data_ok arriving while disc_cnt==0 and no request is pending; this condition SHALL be flagged as an assertion failure in simulation.

Reset
REQ-017 SHALL, while resetn=0, asynchronously clear ms_valid, resp_got, disc_cnt and all registered fields to 0, so that ms2ws_valid=0, ms_gr_we=0, ms_fwd_ready=0 and ms_allowin=1.
REQ-018 SHALL discard pending responses on reset with no counter kept; reset mid-request is legal only if the SRAM is reset too.

Verification
REQ-019 SHALL cover ALU instruction with pc=0x1c000000, alu=0x12345678 and ws_allowin=1 → ms2ws_valid exactly one cycle after entry, ms_final_result=0x12345678.
REQ-020 SHALL cover LB at addr 0x...3 with rdata=0x80FF_0000 and data_ok 3 cycles late → ms_allowin=0 for 3 cycles, then result 0xFFFFFF80 (LBU: 0x00000080).
REQ-021 SHALL cover LH at addr 0x...2 with rdata=0x8001_1234, data_ok while ws_allowin=0 held 2 more cycles → result 0xFFFF8001 delivered after the stall, with no second data_ok required.
REQ-022 SHALL cover flush of a pending LW, then a new LW entering, then two data_ok pulses (0xAAAA_AAAA, then 0x5555_5555) → first discarded, disc_cnt 1→0, new LW returns 0x55555555.
REQ-023 SHALL cover flush in the same cycle as data_ok → disc_cnt stays 0 and the next instruction's data_ok is accepted.
REQ-024 SHALL cover MUL instruction with es_mul_result=0xDEADBEEF, with es_mul_result changed the next cycle → ms_final_result stays 0xDEADBEEF.
